// File: rtl/imem_boot_loader_if.sv
// Instruction-memory port driven by imem_boot_loader: write/read requests and completion.
// READBACK_VERIFY_EN adds the rdata return path used for read-back checking.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);

  logic              request;
  logic              we_re;
  logic [3:0]        mask;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic              valid;
`ifdef READBACK_VERIFY_EN
  logic [31:0]       rdata;
`endif

  modport master (
    output request,
    output we_re,
    output mask,
    output address,
    output data_in,
    input  valid
`ifdef READBACK_VERIFY_EN
    , input rdata
`endif
  );

  modport slave (
    input  request,
    input  we_re,
    input  mask,
    input  address,
    input  data_in,
    output valid
`ifdef READBACK_VERIFY_EN
    , output rdata
`endif
  );

endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: streams program words into instruction memory from address 0, holding the core
// until the image is written. Define READBACK_VERIFY_EN to read back and compare every word.
module imem_boot_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  imem_boot_loader_if.master mem,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_WORD  = 3'd1;
  localparam logic [2:0] WRITE      = 3'd2;
  localparam logic [2:0] WAIT_ACK   = 3'd3;
  localparam logic [2:0] DONE       = 3'd4;
`ifdef READBACK_VERIFY_EN
  localparam logic [2:0] VERIFY     = 3'd5;
  localparam logic [2:0] VERIFY_ACK = 3'd6;
`endif

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic              we_re_q, we_re_d;
  logic [3:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [31:0]       data_in_q, data_in_d;
  logic              last_q, last_d;
  logic              error_q, error_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;

  logic              begin_session;
  logic              commit;
  logic [ADDR_W:0]   wc_inc;

  assign wc_inc = word_count_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    we_re_d       = we_re_q;
    mask_d        = mask_q;
    address_d     = address_q;
    data_in_d     = data_in_q;
    last_d        = last_q;
    error_d       = error_q;
    word_count_d  = word_count_q;
    begin_session = 1'b0;
    commit        = 1'b0;

    case (state_q)
      IDLE:      begin_session = start;
      WAIT_WORD: begin
        if (load_valid) begin
          data_in_d = load_data;
          last_d    = load_last;
          we_re_d   = 1'b1;
          mask_d    = 4'b1111;
          state_d   = WRITE;
        end
      end
      WRITE:     state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (mem.valid) begin
`ifdef READBACK_VERIFY_EN
          // Same address and mask, now as a read of the word just written.
          we_re_d = 1'b0;
          state_d = VERIFY;
`else
          commit = 1'b1;
`endif
        end
      end
`ifdef READBACK_VERIFY_EN
      VERIFY:    state_d = VERIFY_ACK;
      VERIFY_ACK: begin
        if (mem.valid) begin
          if (mem.rdata != data_in_q) begin
            error_d = 1'b1;
            mask_d  = 4'b0000;
            state_d = DONE;
          end else begin
            commit = 1'b1;
          end
        end
      end
`endif
      DONE:      begin_session = start;
      default:   state_d = IDLE;
    endcase

    // Word accepted by memory: count it, advance, then decide on last/overflow.
    if (commit) begin
      word_count_d = wc_inc;
      address_d    = address_q + 1'b1;
      we_re_d      = 1'b0;
      mask_d       = 4'b0000;
      if (last_q) begin
        state_d = DONE;
      end else if (wc_inc == DEPTH_W) begin
        error_d = 1'b1;
        state_d = DONE;
      end else begin
        state_d = WAIT_WORD;
      end
    end

    if (begin_session) begin
      state_d      = WAIT_WORD;
      error_d      = 1'b0;
      word_count_d = '0;
      address_d    = '0;
      we_re_d      = 1'b0;
      mask_d       = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_re_q      <= 1'b0;
      mask_q       <= 4'b0000;
      address_q    <= '0;
      data_in_q    <= '0;
      last_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      we_re_q      <= we_re_d;
      mask_q       <= mask_d;
      address_q    <= address_d;
      data_in_q    <= data_in_d;
      last_q       <= last_d;
      error_q      <= error_d;
      word_count_q <= word_count_d;
    end
  end

  always_comb begin
`ifdef READBACK_VERIFY_EN
    mem.request = (state_q == WRITE) || (state_q == VERIFY);
`else
    mem.request = (state_q == WRITE);
`endif
  end

  assign mem.we_re   = we_re_q;
  assign mem.mask    = mask_q;
  assign mem.address = address_q;
  assign mem.data_in = data_in_q;

  assign load_ready = (state_q == WAIT_WORD);
  assign core_hold  = (state_q != DONE);
  assign done       = (state_q == DONE);
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Initiator that fills the instruction memory before the core runs. It drives the request/we_re/mask/address/data_in interface of instruc_mem_top.
- Takes 32-bit program words from a valid/ready byte-free word stream. Writes them to consecutive word addresses starting at 0.
- Holds the core off until the whole image is written, then releases it.
- Sits at microprocessor level between an external program source and the instruction memory port, muxed ahead of the core's fetch request.

Parameters:
ADDR_W, 8, word-address width; matches pc_address[9:2]
DEPTH, 256, number of writable words; must be <= 2**ADDR_W

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse that begins a load session
load_valid  input  1  stream word valid
load_ready  output  1  loader accepts the stream word this cycle
load_data  input  32  program word
load_last  input  1  marks the final word of the image
request  output  1  memory request pulse
we_re  output  1  1 = write, 0 = read
mask  output  4  byte-enable mask
address  output  ADDR_W  word address
data_in  output  32  write data to memory
valid  input  1  memory completion pulse
core_hold  output  1  1 = core must be held in reset or stall
done  output  1  image written; sticky until next start or reset
error  output  1  overflow or verify failure; sticky until next start or reset
word_count  output  ADDR_W+1  words successfully written this session

Behaviour:
- Reset: all state is cleared on a clk edge with rst=1, including mid-session; any in-flight memory access is abandoned.
  - State goes to IDLE.
  - Outputs at reset: request=0, we_re=0, mask=0, address=0, data_in=0, load_ready=0, done=0, error=0, word_count=0, core_hold=1.
- Memory protocol, decided for this block:
  - request is a single-cycle pulse.
  - we_re, mask, address and data_in are registered and held stable from the request cycle until the cycle valid is sampled high.
  - valid may arrive 1 or more cycles after request.
  - No new request is issued before valid.
- IDLE:
  - load_ready=0.
  - start moves to WAIT_WORD. This clears done, error and word_count, sets core_hold=1 and resets the address pointer to 0.
  - start in any other state is ignored.
- WAIT_WORD:
  - load_ready=1.
  - On load_valid&&load_ready, capture load_data into data_in and capture load_last. Go to WRITE. load_ready drops the next cycle.
- WRITE:
  - On the first cycle, pulse request=1 with we_re=1 and mask=4'b1111. Go to WAIT_ACK.
- WAIT_ACK:
  - On valid: word_count+1 and address+1.
  - If the captured last=1, go to DONE.
  - Else if word_count+1 == DEPTH, set error=1 and go to DONE (overflow: image longer than memory).
  - Else go to WAIT_WORD.
  - A valid seen in any state other than WAIT_ACK is ignored.
- DONE:
  - done=1, core_hold=0, load_ready=0, we_re=0, mask=0.
  - Stays in DONE until start, which behaves as in IDLE.
- Address never wraps. The overflow check stops the loader at DEPTH words; address stays at DEPTH-1+1 truncated and is not used after DONE.
- Throughput: the minimum is 1 word per 3 cycles plus memory latency.
- A 1-word image is valid: load_last on the first word goes to DONE with word_count=1.

Optional Feature:
- Macro READBACK_VERIFY_EN.
- When defined, a VERIFY state follows each write acknowledgement:
  - Issue a request pulse with we_re=0 and mask=4'b1111 at the same address.
  - On valid, compare the memory read-data input against the written word. This adds an extra input port, rdata [31:0].
  - On a mismatch, set error=1 and go to DONE with word_count not incremented.
  - Otherwise continue as in WAIT_ACK: count, advance, then last or overflow checks.
- When undefined: no VERIFY state and no rdata port; error reports overflow only.

Test Plan:
- Reset:
  - Assert rst for 2 cycles, then release. Expect core_hold=1, request=0, done=0, load_ready=0.
  - Hold load_valid=1 without start. Expect load_ready to stay 0.
- 4-word load with 2-cycle memory latency:
  - After start, stream 0x00000013, 0x00100093, 0x00200113, 0x00308193 with load_last on the 4th word.
  - Expect 4 request pulses with we_re=1, mask=4'hF and addresses 0..3.
  - Expect done=1, core_hold=0 and word_count=4.
- Stream stall:
  - Hold load_valid=0 for 10 cycles between words.
  - Expect no extra request pulses and address unchanged.
- Overflow with DEPTH=4:
  - Send 5 words and no load_last.
  - Expect 4 writes, then error=1, done=1 and word_count=4. The 5th word is never accepted (load_ready=0).
- Reset mid-write:
  - Assert rst in WAIT_ACK before valid. Expect IDLE outputs next cycle.
  - A late valid must not change word_count.
- Verify, with READBACK_VERIFY_EN defined:
  - Return rdata=0xDEADBEEF for written word 0x00000013.
  - Expect a read request at address 0, then error=1, done=1 and word_count=0.
